icpu_program_loader: RTL and testbench
======================================

Name: icpu_program_loader

Overview:
- Writer side of the ICPU (PicoBlaze) program memory.
- Accepts a byte stream from the host link and assembles 18-bit instructions. Writes them into the dual-port program RAM write port; the CPU fetch port remains the synchronous reader.
- Holds the ICPU in reset while an image is loaded and validated. Releases it only after a good checksum.

Parameters:
- SYNC_BYTE, 8'hA5, byte value that starts a load frame.
- ADDRESS_WIDTH, 10, program memory address width (1024 words).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts byte. A transfer occurs when in_valid && in_ready at a rising edge.
- mem_write_enable  output  1  program RAM write strobe, one cycle per word.
- mem_write_address  output  ADDRESS_WIDTH  write address.
- mem_write_data  output  18  instruction word.
- cpu_reset  output  1  active-high reset to the ICPU.
- load_busy  output  1  frame in progress.
- load_done  output  1  last frame completed with good checksum (level).
- load_error  output  1  last frame failed (level).

Behaviour:
- Reset (async): state IDLE. Outputs: in_ready=1, mem_write_enable=0, mem_write_address=0, mem_write_data=0, cpu_reset=0 (CPU runs the initial RAM image), load_busy=0, load_done=0, load_error=0.
- Frame format: SYNC, LEN_HI, LEN_LO, then N words of 3 bytes each (B2, B1, B0, big-endian), then CHK.
  - N-1 = {LEN_HI[1:0], LEN_LO}, so N is 1..1024.
  - Word = {B2[1:0], B1, B0}; B2[7:2] is ignored.
- Checksum: CHK must equal the XOR of all bytes from LEN_HI through the last B0. The SYNC byte is excluded.
- States: IDLE, LEN_HI, LEN_LO, B2, B1, B0, WRITE, CHK, DONE, ERROR.
- IDLE/DONE/ERROR:
  - Any accepted byte equal to SYNC_BYTE goes to LEN_HI and asserts cpu_reset=1 and load_busy=1. It clears load_done, load_error, the running XOR, and the word counter.
  - Any other byte is accepted and dropped.
- LEN_HI: if LEN_HI[7:2] != 0, go to ERROR. Otherwise store the byte and go to LEN_LO.
- LEN_LO -> B2 -> B1 -> B0: one accepted byte per state. Bytes are XORed into the running checksum.
- WRITE: entered on the edge that accepts B0; lasts exactly one cycle.
  - mem_write_enable=1, mem_write_address=word counter, mem_write_data=assembled word.
  - in_ready=0 in this cycle.
  - Next: B2 if counter != N-1, else CHK. The counter increments on exit.
- Latency: B0 accepted at edge k; write strobe high between edges k and k+1. Sustained rate is one word per 4 cycles.
- CHK:
  - Match: go to DONE with cpu_reset=0, load_busy=0, load_done=1.
  - Mismatch: go to ERROR with load_error=1, load_busy=0, cpu_reset kept at 1.
- ERROR persists until the next SYNC. RAM contents already written stay written.
- in_ready=1 in every state except WRITE.
- SYNC_BYTE value inside a frame is treated as data; there is no resynchronisation mid-frame.
- The counter does not wrap within a frame, because N <= 2^ADDRESS_WIDTH.
- reset_n asserted mid-frame: immediate return to reset values, including cpu_reset=0. The partially written image is not protected; the host must reload.
- in_valid low in any state: hold state; no output changes except mem_write_enable falling after WRITE.

Test Plan:
- After reset, feed A5 00 00 00 12 34, then CHK=00^00^00^12^34=26 -> single write: address 0, data 18'h01234 (B2=00). cpu_reset high from the edge after A5 until the edge accepting 26; then load_done=1.
- Frame with N=3 (LEN 00 02), words 3FFFF, 00001, 2AAAA (B2 bytes 03, 00, 02) and correct CHK -> writes at addresses 0, 1, 2 in order. Each strobe lasts exactly 1 cycle; in_ready is low on those cycles.
- Same frame with CHK bit-flipped -> all 3 writes occur; load_error=1, load_done=0, cpu_reset stays 1. A following correct frame clears the error and releases the CPU.
- LEN_HI=04 -> ERROR immediately, no writes; subsequent non-SYNC bytes are dropped with in_ready=1.
- Maximum frame LEN 03 FF (1024 words) with in_valid held high -> 1024 writes, addresses 0..1023, last strobe at address 1023; total duration 3+4096+1 accept cycles; load_done=1.
- Assert reset_n low during B1 of word 5 -> all outputs return to reset values asynchronously. A fresh A5 frame afterwards loads correctly from address 0.

Source files
------------

// File: rtl/icpu_program_loader.sv
// ICPU program loader: turns a framed host byte stream into 18-bit program
// RAM writes, holding the ICPU in reset until the image checksum is good.
module icpu_program_loader #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [17:0]              mem_write_data,
  output logic                     cpu_reset,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     load_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_B2, S_B1, S_B0, S_WRITE, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t                   r_state, w_next;
  logic [1:0]               r_len_hi;
  logic [7:0]               r_len_lo;
  logic [1:0]               r_b2;
  logic [7:0]               r_b1, r_b0;
  logic [7:0]               r_xor;
  logic [ADDRESS_WIDTH-1:0] r_cnt;
  logic                     r_cpu_reset, r_busy, r_done, r_error;

  logic                     w_acc;
  logic                     w_sync;
  logic                     w_last;
  logic [9:0]               w_len_m1;

  assign w_acc    = in_valid && in_ready;
  assign w_sync   = (in_data == SYNC_BYTE);
  assign w_len_m1 = {r_len_hi, r_len_lo};
  assign w_last   = (r_cnt == ADDRESS_WIDTH'(w_len_m1));

  // The write cycle is the only one in which no byte can be taken.
  assign in_ready          = (r_state != S_WRITE);
  assign mem_write_enable  = (r_state == S_WRITE);
  assign mem_write_address = r_cnt;
  assign mem_write_data    = {r_b2, r_b1, r_b0};
  assign cpu_reset         = r_cpu_reset;
  assign load_busy         = r_busy;
  assign load_done         = r_done;
  assign load_error        = r_error;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; every state except WRITE advances only on an accepted byte.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (w_acc && w_sync) w_next = S_LEN_HI;
      S_LEN_HI: if (w_acc) w_next = (in_data[7:2] != 6'd0) ? S_ERROR : S_LEN_LO;
      S_LEN_LO: if (w_acc) w_next = S_B2;
      S_B2:     if (w_acc) w_next = S_B1;
      S_B1:     if (w_acc) w_next = S_B0;
      S_B0:     if (w_acc) w_next = S_WRITE;
      S_WRITE:  w_next = w_last ? S_CHK : S_B2;
      S_CHK:    if (w_acc) w_next = (in_data == r_xor) ? S_DONE : S_ERROR;
      default:  w_next = S_IDLE;
    endcase
  end

  // Frame datapath: length, word bytes, running XOR, word counter and status levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len_hi    <= '0;
      r_len_lo    <= '0;
      r_b2        <= '0;
      r_b1        <= '0;
      r_b0        <= '0;
      r_xor       <= '0;
      r_cnt       <= '0;
      r_cpu_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_acc) begin
        unique case (r_state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (w_sync) begin
              r_xor       <= '0;
              r_cnt       <= '0;
              r_cpu_reset <= 1'b1;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_error     <= 1'b0;
            end
          end
          S_LEN_HI: begin
            r_xor    <= r_xor ^ in_data;
            r_len_hi <= in_data[1:0];
            // An oversized length aborts the frame; the CPU stays held in reset.
            if (in_data[7:2] != 6'd0) begin
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end
          end
          S_LEN_LO: begin
            r_xor    <= r_xor ^ in_data;
            r_len_lo <= in_data;
          end
          S_B2: begin
            r_xor <= r_xor ^ in_data;
            r_b2  <= in_data[1:0];
          end
          S_B1: begin
            r_xor <= r_xor ^ in_data;
            r_b1  <= in_data;
          end
          S_B0: begin
            r_xor <= r_xor ^ in_data;
            r_b0  <= in_data;
          end
          S_CHK: begin
            r_busy <= 1'b0;
            if (in_data == r_xor) begin
              r_cpu_reset <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_error     <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (r_state == S_WRITE) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_icpu_program_loader.sv
// Bench for icpu_program_loader: table frames, random frames against a
// frame-level model, and hand sequences for length error, max frame and reset.
module tb_icpu_program_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_write_enable;
  logic [9:0]  mem_write_address;
  logic [17:0] mem_write_data;
  logic        cpu_reset, load_busy, load_done, load_error;

  icpu_program_loader #(.SYNC_BYTE(8'hA5), .ADDRESS_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_write_enable(mem_write_enable),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .cpu_reset(cpu_reset), .load_busy(load_busy), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write monitor: collects strobes, checks single-cycle width and in_ready low.
  typedef struct packed { logic [9:0] a; logic [17:0] d; } wr_t;
  wr_t  wq[$];
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (reset_n && mem_write_enable) begin
      wq.push_back({mem_write_address, mem_write_data});
      chk("ready_low_on_write", {31'd0, in_ready}, 32'd0);
      chk("strobe_one_cycle", {31'd0, prev_we}, 32'd0);
    end
    prev_we = mem_write_enable;
  end

  // Reference image for the frame under test.
  logic [17:0] fw [1024];

  task automatic send_byte(input logic [7:0] b, input bit gap, output int acc_cyc);
    int g;
    @(negedge clk);
    if (gap && ($urandom_range(0, 2) == 0)) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    g = 0;
    while (!in_ready && g < 8) begin
      @(negedge clk);
      g++;
    end
    if (g >= 8) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1 acc_cyc = cyc;
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Builds the byte list from fw[] and sends it; CHK is the XOR of LEN_HI..last B0.
  task automatic send_frame(input int n, input bit corrupt, input bit junk, input bit gaps,
                            output int c0, output int c1);
    logic [7:0] x, b;
    int c;
    x = 8'h00;
    send_byte(8'hA5, gaps, c0);
    chk("cpu_reset_after_sync", {31'd0, cpu_reset}, 32'd1);
    chk("busy_after_sync", {31'd0, load_busy}, 32'd1);
    b = 8'((n - 1) >> 8);   x ^= b; send_byte(b, gaps, c);
    b = 8'((n - 1) & 255);  x ^= b; send_byte(b, gaps, c);
    for (int i = 0; i < n; i++) begin
      b = {junk ? 6'($urandom) : 6'h00, fw[i][17:16]}; x ^= b; send_byte(b, gaps, c);
      b = fw[i][15:8];                                 x ^= b; send_byte(b, gaps, c);
      b = fw[i][7:0];                                  x ^= b; send_byte(b, gaps, c);
    end
    chk("cpu_held_before_chk", {31'd0, cpu_reset}, 32'd1);
    send_byte(x ^ (corrupt ? 8'h01 : 8'h00), gaps, c1);
    go_idle();
  endtask

  task automatic check_writes(input int n);
    repeat (2) @(negedge clk);
    chk("num_writes", wq.size(), n);
    for (int i = 0; i < wq.size() && i < n; i++) begin
      chk("wr_addr", {22'd0, wq[i].a}, i);
      chk("wr_data", {14'd0, wq[i].d}, {14'd0, fw[i]});
    end
    wq.delete();
  endtask

  task automatic check_status(input string tag, input bit e_done, input bit e_err, input bit e_cpu);
    chk({tag, "_done"},  {31'd0, load_done},  {31'd0, e_done});
    chk({tag, "_error"}, {31'd0, load_error}, {31'd0, e_err});
    chk({tag, "_cpu"},   {31'd0, cpu_reset},  {31'd0, e_cpu});
    chk({tag, "_busy"},  {31'd0, load_busy},  32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready},   32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_we"},    {31'd0, mem_write_enable}, 32'd0);
    chk({tag, "_addr"},  {22'd0, mem_write_address}, 32'd0);
    chk({tag, "_data"},  {14'd0, mem_write_data}, 32'd0);
    chk({tag, "_cpu"},   {31'd0, cpu_reset}, 32'd0);
    chk({tag, "_busy"},  {31'd0, load_busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, load_done}, 32'd0);
    chk({tag, "_error"}, {31'd0, load_error}, 32'd0);
  endtask

  typedef struct {
    int          n;
    logic [17:0] w0, w1, w2;
    bit          corrupt;
    bit          e_done, e_err, e_cpu;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c;
    int n;
    bit corrupt;

    tbl[0] = '{n: 1, w0: 18'h01234, w1: 18'h0,     w2: 18'h0,     corrupt: 0, e_done: 1, e_err: 0, e_cpu: 0};
    tbl[1] = '{n: 3, w0: 18'h3FFFF, w1: 18'h00001, w2: 18'h2AAAA, corrupt: 0, e_done: 1, e_err: 0, e_cpu: 0};
    tbl[2] = '{n: 3, w0: 18'h3FFFF, w1: 18'h00001, w2: 18'h2AAAA, corrupt: 1, e_done: 0, e_err: 1, e_cpu: 1};
    tbl[3] = '{n: 3, w0: 18'h3FFFF, w1: 18'h00001, w2: 18'h2AAAA, corrupt: 0, e_done: 1, e_err: 0, e_cpu: 0};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table frames, back to back; the corrupted frame is cleared by the next one.
    for (int t = 0; t < 4; t++) begin
      fw[0] = tbl[t].w0; fw[1] = tbl[t].w1; fw[2] = tbl[t].w2;
      send_frame(tbl[t].n, tbl[t].corrupt, 1'b0, 1'b0, c0, c1);
      check_writes(tbl[t].n);
      check_status("tbl", tbl[t].e_done, tbl[t].e_err, tbl[t].e_cpu);
    end

    // Oversized length: immediate error, later non-sync bytes dropped.
    send_byte(8'hA5, 1'b0, c);
    send_byte(8'h04, 1'b0, c);
    #1;
    chk("lenhi_error", {31'd0, load_error}, 32'd1);
    chk("lenhi_busy", {31'd0, load_busy}, 32'd0);
    chk("lenhi_cpu", {31'd0, cpu_reset}, 32'd1);
    send_byte(8'h00, 1'b0, c);
    send_byte(8'h12, 1'b0, c);
    send_byte(8'h34, 1'b0, c);
    go_idle();
    check_writes(0);
    check_status("lenhi_after", 1'b0, 1'b1, 1'b1);

    // Random frames with idle gaps, leading junk and ignored B2 upper bits.
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 24);
      corrupt = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) fw[i] = 18'($urandom);
      repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 164)), 1'b1, c);
      send_frame(n, corrupt, 1'b1, 1'b1, c0, c1);
      check_writes(n);
      check_status("rand", !corrupt, corrupt, corrupt);
    end

    // Maximum frame with in_valid held high: 1024 writes and fixed duration.
    for (int i = 0; i < 1024; i++) fw[i] = 18'($urandom);
    send_frame(1024, 1'b0, 1'b0, 1'b0, c0, c1);
    chk("max_duration", c1 - c0, 4099);
    check_writes(1024);
    check_status("max", 1'b1, 1'b0, 1'b0);

    // Reset asserted while waiting for B1 of word 5.
    for (int i = 0; i < 10; i++) fw[i] = 18'($urandom);
    send_byte(8'hA5, 1'b0, c);
    send_byte(8'h00, 1'b0, c);
    send_byte(8'h09, 1'b0, c);
    for (int i = 0; i < 5; i++) begin
      send_byte({6'h00, fw[i][17:16]}, 1'b0, c);
      send_byte(fw[i][15:8], 1'b0, c);
      send_byte(fw[i][7:0], 1'b0, c);
    end
    send_byte({6'h00, fw[5][17:16]}, 1'b0, c);
    go_idle();
    chk("midreset_busy_before", {31'd0, load_busy}, 32'd1);
    check_writes(5);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    fw[0] = 18'h3C0DE; fw[1] = 18'h00BAD; fw[2] = 18'h1F00F;
    send_frame(3, 1'b0, 1'b0, 1'b0, c0, c1);
    check_writes(3);
    check_status("postreset", 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
